core_scheduler: RTL and testbench
=================================

CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 SHALL have parameter THREADS, default 4, number of thread lanes per core.
REQ-002 SHALL have parameter PC_W, default 8, program-counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  level request to run one block.
REQ-006 SHALL have port thread_mask  in  THREADS  active lanes, sampled on start acceptance.
REQ-007 SHALL have port instr_valid  in  1  fetcher returned instruction.
REQ-008 SHALL have port dec_mem_rd, dec_mem_wr, dec_reg_we, dec_ret  in  1 each  decoder flags, valid in DECODE.
REQ-009 SHALL have port branch_taken  in  1  and port branch_target  in  PC_W  branch unit result, valid in UPDATE.
REQ-010 SHALL have port lsu_done  in  THREADS  per-lane one-cycle LSU completion pulse.
REQ-011 SHALL have port core_state  out  3  current state encoding.
REQ-012 SHALL have port pc  out  PC_W  current program counter.
REQ-013 SHALL have outputs fetch_req, lsu_req, reg_en, reg_we, done  out  1 each.

Function
REQ-014 SHALL implement states IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7, driven on core_state.
REQ-015 IDLE: start=1 SHALL latch thread_mask, set pc=0, go FETCH next cycle.
REQ-016 FETCH: fetch_req SHALL be 1 every FETCH cycle; instr_valid=1 SHALL move to DECODE; otherwise stay.
REQ-017 DECODE: SHALL latch dec_mem_rd, dec_mem_wr, dec_reg_we, dec_ret into internal flags; go REQUEST after exactly 1 cycle.
REQ-018 REQUEST: lsu_req SHALL be 1 for exactly this one cycle iff latched mem_rd|mem_wr and mask nonzero; clear per-lane done bits; go WAIT.
REQ-019 WAIT: no memory op SHALL go EXECUTE next cycle; with memory op, SHALL OR lsu_done into sticky done bits and go EXECUTE in the cycle after (done_bits|lsu_done) covers every latched mask lane.
REQ-020 lsu_done bits for lanes outside the mask SHALL be ignored; lsu_done arriving in any state other than WAIT SHALL be ignored.
REQ-021 Zero thread_mask SHALL be treated as complete: WAIT lasts 1 cycle, lsu_req stays 0.
REQ-022 EXECUTE: reg_en SHALL be 1 for 1 cycle (operand read); go UPDATE.
REQ-023 UPDATE: reg_en=1, reg_we=latched reg_we, for exactly 1 cycle.
REQ-024 UPDATE with latched ret=1 SHALL go DONE, pc unchanged.
REQ-025 UPDATE otherwise SHALL set pc=branch_target if branch_taken else pc+1 modulo 2^PC_W (255 wraps to 0), then go FETCH.
REQ-026 DONE: done SHALL be 1; start=0 SHALL go IDLE; start held 1 SHALL stay DONE (no relaunch without start low).
REQ-027 start changes outside IDLE/DONE SHALL have no effect; thread_mask SHALL not be resampled mid-block.
REQ-028 fetch_req, lsu_req, reg_en, reg_we, done SHALL be Moore outputs decoded from registered state/flags, no combinational input-to-output path.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, pc=0, all flags, mask, done bits 0, all 1-bit outputs 0, regardless of state, including mid-WAIT.
REQ-030 After reset release, the first transition SHALL require start=1 sampled on a rising edge.

Verification
REQ-031 Non-memory ALU instr, mask=4'b1111, instr_valid 2 cycles after FETCH entry -> states 1,1,1,2,3,4,5,6,1; lsu_req never 1; reg_we=1 one cycle in UPDATE; pc 0->1.
REQ-032 Load, mask=4'b1011, lsu_done pulses lane0 cycle 2, lane1 cycle 5, lane3 cycle 7 of WAIT, lane2 never -> lsu_req one cycle; EXECUTE entered the cycle after lane3 pulse.
REQ-033 pc=255, no branch -> pc=0 after UPDATE; branch_taken=1, target=8'h40 -> pc=8'h40.
REQ-034 ret instr -> DONE, done=1 while start=1; start drops -> IDLE next cycle, done=0.
REQ-035 reset asserted in WAIT with partial lsu_done -> IDLE immediately, outputs 0; restart with mask=0 store -> WAIT one cycle, lsu_req 0.

Source files
------------

// File: rtl/core_scheduler.sv
// Per-core block scheduler: fetch, decode, LSU request/wait, execute, update for a thread group.
// Outputs are Moore-decoded from state/flags. LSU backpressure is absorbed by waiting on per-lane done pulses.
module core_scheduler #(
    parameter int THREADS = 4,
    parameter int PC_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [THREADS-1:0] thread_mask,
    input  logic               instr_valid,
    input  logic               dec_mem_rd,
    input  logic               dec_mem_wr,
    input  logic               dec_reg_we,
    input  logic               dec_ret,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [THREADS-1:0] lsu_done,
    output logic [2:0]         core_state,
    output logic [PC_W-1:0]    pc,
    output logic               fetch_req,
    output logic               lsu_req,
    output logic               reg_en,
    output logic               reg_we,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [THREADS-1:0] mask_q, mask_d;
    logic [THREADS-1:0] done_bits_q, done_bits_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic               reg_we_q, reg_we_d;
    logic               ret_q, ret_d;
    logic               mem_op;

    assign mem_op = mem_rd_q | mem_wr_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mask_d      = mask_q;
        done_bits_d = done_bits_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        reg_we_d    = reg_we_q;
        ret_d       = ret_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = thread_mask;
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (instr_valid) state_d = S_DECODE;
            end
            S_DECODE: begin
                mem_rd_d = dec_mem_rd;
                mem_wr_d = dec_mem_wr;
                reg_we_d = dec_reg_we;
                ret_d    = dec_ret;
                state_d  = S_REQUEST;
            end
            S_REQUEST: begin
                done_bits_d = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (!mem_op) begin
                    state_d = S_EXECUTE;
                end else begin
                    // Only masked lanes accumulate, so an empty mask is complete at once.
                    done_bits_d = done_bits_q | (lsu_done & mask_q);
                    if (done_bits_d == mask_q) state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (ret_q) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = branch_taken ? branch_target : pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            mask_q      <= '0;
            done_bits_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            ret_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mask_q      <= mask_d;
            done_bits_q <= done_bits_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            reg_we_q    <= reg_we_d;
            ret_q       <= ret_d;
        end
    end

    assign core_state = state_q;
    assign pc         = pc_q;
    assign fetch_req  = (state_q == S_FETCH);
    assign lsu_req    = (state_q == S_REQUEST) && mem_op && (|mask_q);
    assign reg_en     = (state_q == S_EXECUTE) || (state_q == S_UPDATE);
    assign reg_we     = (state_q == S_UPDATE) && reg_we_q;
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: per-cycle vector table plus a reset-in-WAIT sequence.
module tb_core_scheduler;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] thread_mask;
    logic       instr_valid;
    logic       dec_mem_rd, dec_mem_wr, dec_reg_we, dec_ret;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [3:0] lsu_done;
    logic [2:0] core_state;
    logic [7:0] pc;
    logic       fetch_req, lsu_req, reg_en, reg_we, done;

    int n_chk  = 0;
    int n_fail = 0;

    core_scheduler #(.THREADS(4), .PC_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_mask(thread_mask),
        .instr_valid(instr_valid), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
        .dec_reg_we(dec_reg_we), .dec_ret(dec_ret), .branch_taken(branch_taken),
        .branch_target(branch_target), .lsu_done(lsu_done), .core_state(core_state),
        .pc(pc), .fetch_req(fetch_req), .lsu_req(lsu_req), .reg_en(reg_en),
        .reg_we(reg_we), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each row: expected outputs of the current cycle, and inputs applied before the next edge.
    typedef struct {
        logic [2:0] st;
        logic [7:0] pc;
        logic [4:0] o;   // {fetch_req, lsu_req, reg_en, reg_we, done}
        logic       s;
        logic [3:0] m;
        logic       iv;
        logic [3:0] d;   // {mem_rd, mem_wr, reg_we, ret}
        logic       bt;
        logic [7:0] tg;
        logic [3:0] ls;
    } vec_t;

    vec_t tbl[44];

    function automatic vec_t v(input logic [2:0] st, input logic [7:0] p, input logic [4:0] o,
                               input logic s, input logic [3:0] m, input logic iv,
                               input logic [3:0] d, input logic bt, input logic [7:0] tg,
                               input logic [3:0] ls);
        vec_t r;
        r.st = st; r.pc = p; r.o = o; r.s = s; r.m = m; r.iv = iv;
        r.d = d; r.bt = bt; r.tg = tg; r.ls = ls;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic [7:0] p,
                           input logic [4:0] o);
        chk({tag, " state"}, 16'(core_state), 16'(st));
        chk({tag, " pc"}, 16'(pc), 16'(p));
        chk({tag, " outs"}, 16'({fetch_req, lsu_req, reg_en, reg_we, done}), 16'(o));
    endtask

    task automatic set_dec(input logic [3:0] d);
        {dec_mem_rd, dec_mem_wr, dec_reg_we, dec_ret} = d;
    endtask

    initial begin
        // ALU instr, mask 1111, instr_valid on third FETCH cycle
        tbl[0]  = v(0, 8'h00, 5'b00000, 1, 4'hF, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[1]  = v(1, 8'h00, 5'b10000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[2]  = v(1, 8'h00, 5'b10000, 1, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[3]  = v(1, 8'h00, 5'b10000, 0, 4'h0, 1, 4'b0000, 0, 8'h00, 4'h0);
        tbl[4]  = v(2, 8'h00, 5'b00000, 0, 4'h0, 0, 4'b0010, 0, 8'h00, 4'h0);
        tbl[5]  = v(3, 8'h00, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[6]  = v(4, 8'h00, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'hF);
        tbl[7]  = v(5, 8'h00, 5'b00100, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[8]  = v(6, 8'h00, 5'b00110, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        // ret instr, then DONE held by start
        tbl[9]  = v(1, 8'h01, 5'b10000, 0, 4'h0, 1, 4'b0000, 0, 8'h00, 4'h0);
        tbl[10] = v(2, 8'h01, 5'b00000, 0, 4'h0, 0, 4'b0001, 0, 8'h00, 4'h0);
        tbl[11] = v(3, 8'h01, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[12] = v(4, 8'h01, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[13] = v(5, 8'h01, 5'b00100, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[14] = v(6, 8'h01, 5'b00100, 1, 4'h0, 0, 4'b0000, 1, 8'h40, 4'h0);
        tbl[15] = v(7, 8'h01, 5'b00001, 1, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[16] = v(7, 8'h01, 5'b00001, 1, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[17] = v(7, 8'h01, 5'b00001, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        // Load with mask 1011; lanes 0,1,3 complete on WAIT cycles 2,5,7
        tbl[18] = v(0, 8'h01, 5'b00000, 1, 4'hB, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[19] = v(1, 8'h00, 5'b10000, 0, 4'h0, 1, 4'b0000, 0, 8'h00, 4'h0);
        tbl[20] = v(2, 8'h00, 5'b00000, 1, 4'h0, 0, 4'b1000, 0, 8'h00, 4'hB);
        tbl[21] = v(3, 8'h00, 5'b01000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'hB);
        tbl[22] = v(4, 8'h00, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[23] = v(4, 8'h00, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h1);
        tbl[24] = v(4, 8'h00, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h4);
        tbl[25] = v(4, 8'h00, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[26] = v(4, 8'h00, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h2);
        tbl[27] = v(4, 8'h00, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[28] = v(4, 8'h00, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h8);
        tbl[29] = v(5, 8'h00, 5'b00100, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[30] = v(6, 8'h00, 5'b00100, 0, 4'h0, 0, 4'b0000, 1, 8'h40, 4'h0);
        // Branch to 0x40, then to 0xFF, then fall through with wrap to 0
        tbl[31] = v(1, 8'h40, 5'b10000, 0, 4'h0, 1, 4'b0000, 0, 8'h00, 4'h0);
        tbl[32] = v(2, 8'h40, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[33] = v(3, 8'h40, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[34] = v(4, 8'h40, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h3);
        tbl[35] = v(5, 8'h40, 5'b00100, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[36] = v(6, 8'h40, 5'b00100, 0, 4'h0, 0, 4'b0000, 1, 8'hFF, 4'h0);
        tbl[37] = v(1, 8'hFF, 5'b10000, 0, 4'h0, 1, 4'b0000, 0, 8'h00, 4'h0);
        tbl[38] = v(2, 8'hFF, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[39] = v(3, 8'hFF, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[40] = v(4, 8'hFF, 5'b00000, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[41] = v(5, 8'hFF, 5'b00100, 0, 4'h0, 0, 4'b0000, 0, 8'h00, 4'h0);
        tbl[42] = v(6, 8'hFF, 5'b00100, 0, 4'h0, 0, 4'b0000, 0, 8'h40, 4'h0);
        tbl[43] = v(1, 8'h00, 5'b10000, 0, 4'h0, 1, 4'b0000, 0, 8'h00, 4'h0);

        reset = 1'b0; start = 1'b0; thread_mask = 4'h0; instr_valid = 1'b0;
        set_dec(4'b0000); branch_taken = 1'b0; branch_target = 8'h00; lsu_done = 4'h0;

        repeat (2) @(negedge clk);
        chk_all("reset", 3'd0, 8'h00, 5'b00000);
        reset = 1'b1;
        @(negedge clk);
        chk_all("post_reset_idle", 3'd0, 8'h00, 5'b00000);

        for (int i = 0; i < 44; i++) begin
            if (i != 0) @(negedge clk);
            chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].pc, tbl[i].o);
            start         = tbl[i].s;
            thread_mask   = tbl[i].m;
            instr_valid   = tbl[i].iv;
            set_dec(tbl[i].d);
            branch_taken  = tbl[i].bt;
            branch_target = tbl[i].tg;
            lsu_done      = tbl[i].ls;
        end

        // Store with mask 1011, reset while only lane 0 has completed
        @(negedge clk);
        chk_all("rst_seq decode", 3'd2, 8'h00, 5'b00000);
        instr_valid = 1'b0; set_dec(4'b0100);
        @(negedge clk);
        chk_all("rst_seq request", 3'd3, 8'h00, 5'b01000);
        set_dec(4'b0000);
        @(negedge clk);
        chk_all("rst_seq wait1", 3'd4, 8'h00, 5'b00000);
        lsu_done = 4'h1;
        @(negedge clk);
        lsu_done = 4'h0;
        chk_all("rst_seq wait2", 3'd4, 8'h00, 5'b00000);
        #2 reset = 1'b0;
        #1 chk_all("rst_seq async", 3'd0, 8'h00, 5'b00000);
        @(negedge clk);
        chk_all("rst_seq held", 3'd0, 8'h00, 5'b00000);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk_all("rst_seq no_start", 3'd0, 8'h00, 5'b00000);
        start = 1'b1; thread_mask = 4'h0;

        // Zero-mask store: no LSU request, single WAIT cycle
        @(negedge clk);
        chk_all("zmask fetch", 3'd1, 8'h00, 5'b10000);
        start = 1'b0; instr_valid = 1'b1;
        @(negedge clk);
        chk_all("zmask decode", 3'd2, 8'h00, 5'b00000);
        instr_valid = 1'b0; set_dec(4'b0100);
        @(negedge clk);
        chk_all("zmask request", 3'd3, 8'h00, 5'b00000);
        set_dec(4'b0000);
        @(negedge clk);
        chk_all("zmask wait", 3'd4, 8'h00, 5'b00000);
        @(negedge clk);
        chk_all("zmask execute", 3'd5, 8'h00, 5'b00100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
